// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: synchronizes ss/sclk/mosi into clk, receives FRAME_W-bit frames
// MSB first and returns a preloaded word on miso. Aborted or overlong frames pulse frame_err.
module spi_slave_rx #(
  parameter int FRAME_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ss,
  input  logic               sclk,
  input  logic               mosi,
  output logic               miso,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               tx_load,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               busy
);

  localparam int CNT_W   = $clog2(FRAME_W) + 1;
  localparam int FLUSH_N = SYNC_STAGES + 1;
  localparam int FLUSH_W = $clog2(FLUSH_N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, OVER} state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] ss_sync_reg, sclk_sync_reg, mosi_sync_reg;
  logic                   ss_prev_reg, sclk_prev_reg;
  logic [FLUSH_W-1:0]     flush_cnt_reg;
  logic                   ss_s, sclk_s, mosi_s, flushed;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

  logic [FRAME_W-1:0]     tx_buf_reg, tx_shift_reg, rx_shift_reg, rx_data_reg;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic                   rx_valid_reg, frame_err_reg, busy_reg, over_err_reg;

  logic                   start, shift_in, shift_out, rx_done, err_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync_reg   <= '1;
      sclk_sync_reg <= '0;
      mosi_sync_reg <= '0;
      ss_prev_reg   <= 1'b1;
      sclk_prev_reg <= 1'b0;
      flush_cnt_reg <= '0;
    end else begin
      ss_sync_reg[0]   <= ss;
      sclk_sync_reg[0] <= sclk;
      mosi_sync_reg[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ss_sync_reg[i]   <= ss_sync_reg[i-1];
        sclk_sync_reg[i] <= sclk_sync_reg[i-1];
        mosi_sync_reg[i] <= mosi_sync_reg[i-1];
      end
      ss_prev_reg   <= ss_s;
      sclk_prev_reg <= sclk_s;
      if (!flushed) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign ss_s   = ss_sync_reg[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  // Edges are ignored until the reset values have drained out of the synchronizers,
  // so an ss already held low across reset cannot look like a fresh ss_fall.
  assign flushed   = (flush_cnt_reg == FLUSH_W'(FLUSH_N));
  assign sclk_rise = flushed &&  sclk_s && !sclk_prev_reg;
  assign sclk_fall = flushed && !sclk_s &&  sclk_prev_reg;
  assign ss_fall   = flushed && !ss_s   &&  ss_prev_reg;
  assign ss_rise   = flushed &&  ss_s   && !ss_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    shift_in   = 1'b0;
    shift_out  = 1'b0;
    rx_done    = 1'b0;
    err_pulse  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ss_fall) begin
          state_next = SHIFT;
          start      = 1'b1;
        end
      end
      SHIFT: begin
        // ss_rise outranks a coincident sclk_rise
        if (ss_rise) begin
          state_next = IDLE;
          err_pulse  = (bit_cnt_reg != '0);
        end else begin
          if (sclk_rise) begin
            shift_in = 1'b1;
            if (bit_cnt_reg == CNT_W'(FRAME_W - 1)) begin
              state_next = OVER;
              rx_done    = 1'b1;
            end
          end
          if (sclk_fall) shift_out = 1'b1;
        end
      end
      OVER: begin
        if (ss_rise)                         state_next = IDLE;
        else if (sclk_rise && !over_err_reg) err_pulse  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_buf_reg    <= '0;
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      rx_data_reg   <= '0;
      bit_cnt_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      busy_reg      <= 1'b0;
      over_err_reg  <= 1'b0;
    end else begin
      rx_valid_reg  <= rx_done;
      frame_err_reg <= err_pulse;
      busy_reg      <= (state_next != IDLE);
      if (tx_load) tx_buf_reg <= tx_data;
      if (start) begin
        tx_shift_reg <= tx_buf_reg;
        bit_cnt_reg  <= '0;
        over_err_reg <= 1'b0;
      end
      if (shift_in) begin
        rx_shift_reg <= {rx_shift_reg[FRAME_W-2:0], mosi_s};
        bit_cnt_reg  <= bit_cnt_reg + 1'b1;
      end
      if (shift_out) tx_shift_reg <= {tx_shift_reg[FRAME_W-2:0], 1'b0};
      if (rx_done)   rx_data_reg  <= {rx_shift_reg[FRAME_W-2:0], mosi_s};
      if (err_pulse && state_reg == OVER) over_err_reg <= 1'b1;
    end
  end

  assign miso      = (state_reg == SHIFT) ? tx_shift_reg[FRAME_W-1] : 1'b0;
  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign busy      = busy_reg;

endmodule
